// File: rtl/b_calc_pkg.sv
// b_calc_pkg: shared definitions for the B-side calc unit.
//   - 3-bit op codes (pairwise ops 0-3, reductions 4-7)
//   - FSM state encoding
//   - ops_needed(): beats per transaction for a given op
package b_calc_pkg;

  localparam logic [2:0] OP_ADD2 = 3'd0;
  localparam logic [2:0] OP_SUB2 = 3'd1;
  localparam logic [2:0] OP_OR2  = 3'd2;
  localparam logic [2:0] OP_AND2 = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_SUM  = 3'd6;
  localparam logic [2:0] OP_AVG  = 3'd7;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_RESULT  = 1'b1
  } state_t;

  // Pairwise ops (msb clear) take two operands; reductions take num_ops.
  function automatic int unsigned ops_needed(input logic [2:0] op,
                                             input int unsigned num_ops);
    return op[2] ? num_ops : 2;
  endfunction

endpackage

// File: rtl/b_calc_alu.sv
// b_calc_alu: combinational accumulate step plus final-result mux.
//   op       : latched op code
//   acc      : current accumulator (ACC_W bits, wide enough for an
//              unwrapped NUM_OPS-operand sum)
//   operand  : incoming operand word
//   acc_next : accumulator after folding in operand
//   result   : DATA_W result taken from acc_next (AVG shifts by log2)
module b_calc_alu
  import b_calc_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_OPS = 4,
  parameter int SH      = $clog2(NUM_OPS),
  parameter int ACC_W   = DATA_W + SH
) (
  input  logic [2:0]        op,
  input  logic [ACC_W-1:0]  acc,
  input  logic [DATA_W-1:0] operand,
  output logic [ACC_W-1:0]  acc_next,
  output logic [DATA_W-1:0] result
);

  logic [ACC_W-1:0] opnd_x;
  assign opnd_x = ACC_W'(operand);

  always_comb begin
    acc_next = acc;
    case (op)
      OP_ADD2, OP_SUM, OP_AVG: acc_next = acc + opnd_x;
      OP_SUB2:                 acc_next = acc - opnd_x;
      OP_OR2,  OP_OR:          acc_next = acc | opnd_x;
      OP_AND2, OP_AND:         acc_next = acc & opnd_x;
      default:                 acc_next = acc;
    endcase
  end

  // AVG divides the unwrapped sum by NUM_OPS (a power of two); all other
  // ops keep the low DATA_W bits, which gives modulo-2^32 wrap for ADD/SUB/SUM.
  assign result = (op == OP_AVG) ? acc_next[SH +: DATA_W] : acc_next[DATA_W-1:0];

endmodule

// File: rtl/b_calc_unit.sv
// b_calc_unit: collects operand beats from the A stream, folds them with
// the op latched on the first beat, and presents one result on the B side.
//   clk, rstn          : clock, async active-low reset
//   a_valid/a_data     : operand stream in; a_ready high only in COLLECT
//   b_operation        : op code, sampled on the first beat of a transaction
//   b_valid/b_result   : result out, held stable until b_ready
//   b_ready            : consumer accept
module b_calc_unit
  import b_calc_pkg::*;
#(
  parameter int NUM_OPS = 4,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic [2:0]        b_operation,
  output logic              b_valid,
  output logic [DATA_W-1:0] b_result,
  input  logic              b_ready
);

  localparam int SH    = $clog2(NUM_OPS);
  localparam int ACC_W = DATA_W + SH;
  localparam int CNT_W = $clog2(NUM_OPS + 1);

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d, cnt_inc, k;
  logic [2:0]         op_q, op_d;
  logic [ACC_W-1:0]   acc, acc_d, alu_acc;
  logic [DATA_W-1:0]  res_d, alu_res;
  logic               beat;

  b_calc_alu #(.DATA_W(DATA_W), .NUM_OPS(NUM_OPS)) u_alu (
    .op       (op_q),
    .acc      (acc),
    .operand  (a_data),
    .acc_next (alu_acc),
    .result   (alu_res)
  );

  // Handshake flags decode straight from state, so COLLECT and RESULT
  // can never overlap and both flip on the same edge.
  assign a_ready = (state == ST_COLLECT);
  assign b_valid = (state == ST_RESULT);
  assign beat    = a_valid & a_ready;
  assign cnt_inc = cnt + 1'b1;
  // k only matters from the second beat on, when op_q already holds the op.
  assign k       = CNT_W'(ops_needed(op_q, NUM_OPS));

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    op_d    = op_q;
    acc_d   = acc;
    res_d   = b_result;
    case (state)
      ST_COLLECT: begin
        if (beat) begin
          if (cnt == '0) begin
            op_d  = b_operation;
            acc_d = ACC_W'(a_data);
            cnt_d = cnt_inc;
          end else begin
            acc_d = alu_acc;
            if (cnt_inc == k) begin
              res_d   = alu_res;
              state_d = ST_RESULT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
      end
      ST_RESULT: begin
        if (b_ready) state_d = ST_COLLECT;
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_COLLECT;
      cnt      <= '0;
      op_q     <= '0;
      acc      <= '0;
      b_result <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      op_q     <= op_d;
      acc      <= acc_d;
      b_result <= res_d;
    end
  end

endmodule
